// File: rtl/demux1to2_32bit_stream.sv
// Purpose: 1-to-2 valid/ready stream demux with per-packet output lock and per-output packet counters.
// Latency: 1 cycle from input transfer to output valid; counters update 1 cycle after the delivering transfer.
// Backpressure: in_ready drops only when the target slot is full and its sink is not ready; the other output drains freely.
module demux1to2_32bit_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               out0_valid_q, out0_valid_d;
    logic               out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0]   out0_data_q, out0_data_d;
    logic [WIDTH-1:0]   out1_data_q, out1_data_d;
    logic               out0_last_q, out0_last_d;
    logic               out1_last_q, out1_last_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic target;
    logic in_fire;
    logic out0_fire;
    logic out1_fire;

    // Destination select, ready generation and the packet-lock state machine.
    always_comb begin
        state_d  = state_q;
        target   = 1'b0;
        case (state_q)
            IDLE:    target = in_sel;
            LOCK0:   target = 1'b0;
            LOCK1:   target = 1'b1;
            default: target = 1'b0;
        endcase

        // A full slot can still accept when its sink takes the old beat this cycle.
        in_ready = target ? (!out1_valid_q || out1_ready)
                          : (!out0_valid_q || out0_ready);
        in_fire  = in_valid && in_ready;

        if (in_fire) begin
            if (in_last) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                state_d = in_sel ? LOCK1 : LOCK0;
            end
        end
    end

    // Output slots: load on a targeted input transfer, otherwise clear on drain, and count delivered packets.
    always_comb begin
        out0_fire    = out0_valid_q && out0_ready;
        out1_fire    = out1_valid_q && out1_ready;

        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        out0_last_d  = out0_last_q;
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        out1_last_d  = out1_last_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (in_fire && !target) begin
            out0_valid_d = 1'b1;
            out0_data_d  = in_data;
            out0_last_d  = in_last;
        end else if (out0_fire) begin
            out0_valid_d = 1'b0;
        end

        if (in_fire && target) begin
            out1_valid_d = 1'b1;
            out1_data_d  = in_data;
            out1_last_d  = in_last;
        end else if (out1_fire) begin
            out1_valid_d = 1'b0;
        end

        if (out0_fire && out0_last_q) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (out1_fire && out1_last_q) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // State, slot and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
            out0_last_q  <= 1'b0;
            out1_last_q  <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
            out0_last_q  <= out0_last_d;
            out1_last_q  <= out1_last_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out0_valid = out0_valid_q;
    assign out1_valid = out1_valid_q;
    assign out0_data  = out0_data_q;
    assign out1_data  = out1_data_q;
    assign out0_last  = out0_last_q;
    assign out1_last  = out1_last_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux1to2_32bit_stream.sv
// Scoreboard bench for demux1to2_32bit_stream (counter width 4 so the wrap case is short).
module tb_demux1to2_32bit_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, in_sel;
    logic [31:0] in_data;
    logic        out0_valid, out0_ready, out0_last;
    logic        out1_valid, out1_ready, out1_last;
    logic [31:0] out0_data, out1_data;
    logic [3:0]  cnt0, cnt1;

    demux1to2_32bit_stream #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_sel(in_sel),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_data(out0_data), .out0_last(out0_last),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out1_data(out1_data), .out1_last(out1_last),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    int lock = 2;   // 2 = idle, otherwise the locked output

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer is compared against the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_valid && out0_ready) begin
                if (exp0_q.size() == 0) begin
                    check("out0_unexpected_beat", {31'd0, out0_last, out0_data}, 64'd0);
                end else begin
                    automatic logic [32:0] e = exp0_q.pop_front();
                    check("out0_beat", {31'd0, out0_last, out0_data}, {31'd0, e});
                    if (e[32]) exp_cnt0++;
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1_q.size() == 0) begin
                    check("out1_unexpected_beat", {31'd0, out1_last, out1_data}, 64'd0);
                end else begin
                    automatic logic [32:0] e = exp1_q.pop_front();
                    check("out1_beat", {31'd0, out1_last, out1_data}, {31'd0, e});
                    if (e[32]) exp_cnt1++;
                end
            end
        end
    end

    task automatic send_beat(input logic sel, input logic [31:0] d, input logic last);
        bit ok = 0;
        int dest;
        in_valid = 1'b1; in_sel = sel; in_data = d; in_last = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("send_timeout", 64'd0, 64'd1);
        end else begin
            dest = (lock == 2) ? int'(sel) : lock;
            if (dest == 0) exp0_q.push_back({last, d});
            else           exp1_q.push_back({last, d});
            lock = last ? 2 : dest;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain_and_check_counts(input string name);
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            if (exp0_q.size() == 0 && exp1_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check({name, "_drain_timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        check({name, "_cnt0"}, {60'd0, cnt0}, {60'd0, 4'(exp_cnt0)});
        check({name, "_cnt1"}, {60'd0, cnt1}, {60'd0, 4'(exp_cnt1)});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            in_valid = 1'(($urandom)); in_sel = 1'($urandom); in_last = 1'($urandom);
            in_data = $urandom; out0_ready = 1'($urandom); out1_ready = 1'($urandom);
        end
        in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0;
        rst_n = 1'b1;
        exp0_q.delete(); exp1_q.delete();
        exp_cnt0 = 0; exp_cnt1 = 0; lock = 2;
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; in_valid = 0; in_sel = 0; in_last = 0; in_data = 0;
        out0_ready = 0; out1_ready = 0;

        // 1. Reset values
        do_reset();
        out0_ready = 1'b0; out1_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_valids", {62'd0, out0_valid, out1_valid}, 64'd0);
        check("rst_data", {out0_data, out1_data}, 64'd0);
        check("rst_lasts", {62'd0, out0_last, out1_last}, 64'd0);
        check("rst_cnts", {56'd0, cnt0, cnt1}, 64'd0);
        @(posedge clk); #1;

        // 2. Single beat to out1
        out0_ready = 1'b1; out1_ready = 1'b1;
        send_beat(1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        check("single_out1_valid", {63'd0, out1_valid}, 64'd1);
        check("single_out1_data", {32'd0, out1_data}, {32'd0, 32'hDEADBEEF});
        check("single_out0_idle", {63'd0, out0_valid}, 64'd0);
        drain_and_check_counts("single");

        // 3. Packet lock: in_sel toggles after the first beat, all beats stay on out0
        send_beat(1'b0, 32'hA0A0_0000, 1'b0);
        send_beat(1'b1, 32'hA1A1_1111, 1'b0);
        send_beat(1'b0, 32'hA2A2_2222, 1'b0);
        send_beat(1'b1, 32'hA3A3_3333, 1'b1);
        drain_and_check_counts("lock");
        // state back in IDLE: next sel=1 single beat goes to out1
        send_beat(1'b1, 32'h0000_1DE1, 1'b1);
        drain_and_check_counts("lock_idle");

        // 4. Backpressure on out0
        out0_ready = 1'b0;
        send_beat(1'b0, 32'hB0B0_B0B0, 1'b0);
        fork
            send_beat(1'b0, 32'hB1B1_B1B1, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                    check("bp_data_stable", {32'd0, out0_data}, {32'd0, 32'hB0B0_B0B0});
                end
                @(posedge clk); #1;
                out0_ready = 1'b1;
            end
        join
        c0 = cyc;
        send_beat(1'b1, 32'hB2B2_B2B2, 1'b0);
        send_beat(1'b0, 32'hB3B3_B3B3, 1'b0);
        send_beat(1'b1, 32'hB4B4_B4B4, 1'b1);
        check("bp_throughput_cycles", 64'(cyc - c0), 64'd3);
        drain_and_check_counts("bp");

        // 5. Interleave: out1 packet held while an out0 packet flows
        out1_ready = 1'b0;
        send_beat(1'b1, 32'hC1C1_0001, 1'b1);
        send_beat(1'b0, 32'hC0C0_0000, 1'b0);
        send_beat(1'b0, 32'hC0C0_0001, 1'b0);
        send_beat(1'b0, 32'hC0C0_0002, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("il_out1_held", {31'd0, out1_valid, out1_data}, {31'd0, 1'b1, 32'hC1C1_0001});
        check("il_out0_drained", {63'd0, out0_valid}, 64'd0);
        @(posedge clk); #1;
        out1_ready = 1'b1;
        drain_and_check_counts("il");

        // 6a. Reset mid-packet: beat 1 held in slot1, beat 2 offered, then reset
        out1_ready = 1'b0;
        send_beat(1'b1, 32'hD0D0_0000, 1'b0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hD1D1_1111; in_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; in_sel = 1'b0;
        exp0_q.delete(); exp1_q.delete(); exp_cnt0 = 0; exp_cnt1 = 0; lock = 2;
        @(negedge clk);
        check("mid_rst_valids", {62'd0, out0_valid, out1_valid}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_cnts", {56'd0, cnt0, cnt1}, 64'd0);
        @(posedge clk); #1;
        out1_ready = 1'b1;
        send_beat(1'b0, 32'hE0E0_0000, 1'b1);
        send_beat(1'b1, 32'hE1E1_1111, 1'b1);
        drain_and_check_counts("mid_rst");

        // 6b. Counter wrap: 17 packets on out0 with a 4-bit counter reads 1
        do_reset();
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) send_beat(1'b0, 32'hF000_0000 + 32'(i), 1'b1);
        drain_and_check_counts("wrap");
        check("wrap_cnt0_is_1", {60'd0, cnt0}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
